// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port 16-bit memory between CPU fetch and load/store ports.
// Load/store wins by default; a bounded streak counter guarantees fetch progress.
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY   = 1,
  parameter int unsigned MAX_LS_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_if_req,
  input  logic [15:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rdvalid,
  output logic [15:0] o_if_rddata,
  output logic        o_stall_if,
  input  logic        i_ls_rd,
  input  logic        i_ls_wr,
  input  logic [15:0] i_ls_addr,
  input  logic [15:0] i_ls_wrdata,
  output logic        o_ls_gnt,
  output logic        o_ls_rdvalid,
  output logic [15:0] o_ls_rddata,
  output logic [15:0] o_mem_addr,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic [15:0] o_mem_wrdata,
  input  logic [15:0] i_mem_rddata,
  output logic        o_err
);

  localparam int unsigned CW = $clog2(MEM_LATENCY + 1);
  localparam int unsigned SW = $clog2(MAX_LS_STREAK + 1);

  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_LS} owner_t;

  state_t        state_q,   state_d;
  owner_t        owner_q,   owner_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic [SW-1:0] streak_q,  streak_d;
  logic          err_q,     err_d;
  logic [15:0]   if_data_q, if_data_d;
  logic [15:0]   ls_data_q, ls_data_d;

  logic data_ret;
  logic can_grant;
  logic ls_req;
  logic streak_full;
  logic gnt_ls;
  logic gnt_if;
  logic rd_issue;

  always_comb begin
    data_ret    = (state_q == WAIT) && (cnt_q == CW'(1));
    // Grants are masked during reset so nothing reaches memory while reset is low.
    can_grant   = reset && ((state_q == IDLE) || data_ret);
    ls_req      = i_ls_rd | i_ls_wr;
    streak_full = (streak_q == SW'(MAX_LS_STREAK));
    gnt_ls      = can_grant && ls_req && !(i_if_req && streak_full);
    gnt_if      = can_grant && !gnt_ls && i_if_req;
    rd_issue    = gnt_if || (gnt_ls && !i_ls_wr);
  end

  always_comb begin
    o_mem_addr   = '0;
    o_mem_wrdata = '0;
    o_mem_rd     = 1'b0;
    o_mem_wr     = 1'b0;
    if (gnt_ls) begin
      o_mem_addr = i_ls_addr;
      if (i_ls_wr) begin
        o_mem_wr     = 1'b1;
        o_mem_wrdata = i_ls_wrdata;
      end else begin
        o_mem_rd = 1'b1;
      end
    end else if (gnt_if) begin
      o_mem_addr = i_if_addr;
      o_mem_rd   = 1'b1;
    end
  end

  always_comb begin
    o_if_gnt     = gnt_if;
    o_ls_gnt     = gnt_ls;
    o_stall_if   = reset & i_if_req & ~gnt_if;
    o_if_rdvalid = data_ret && (owner_q == OWN_IF);
    o_ls_rdvalid = data_ret && (owner_q == OWN_LS);
    o_if_rddata  = o_if_rdvalid ? i_mem_rddata : if_data_q;
    o_ls_rddata  = o_ls_rdvalid ? i_mem_rddata : ls_data_q;
    o_err        = err_q;
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    streak_d  = streak_q;
    err_d     = err_q | (i_ls_rd & i_ls_wr);
    if_data_d = o_if_rddata;
    ls_data_d = o_ls_rddata;

    // A read issued in the return cycle re-arms WAIT directly (back-to-back).
    if (rd_issue) begin
      state_d = WAIT;
      cnt_d   = CW'(MEM_LATENCY);
      owner_d = gnt_ls ? OWN_LS : OWN_IF;
    end else if (data_ret) begin
      state_d = IDLE;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - CW'(1);
    end

    if (!i_if_req || gnt_if) begin
      streak_d = '0;
    end else if (gnt_ls && !streak_full) begin
      streak_d = streak_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_IF;
      cnt_q     <= '0;
      streak_q  <= '0;
      err_q     <= 1'b0;
      if_data_q <= '0;
      ls_data_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      streak_q  <= streak_d;
      err_q     <= err_d;
      if_data_q <= if_data_d;
      ls_data_q <= ls_data_d;
    end
  end

endmodule
